// File: rtl/esp8266_uart_tx_pkg.sv
// Shared definitions for the ESP8266 UART transmit path: FSM states,
// default line parameters and the baud divider helper.
package esp8266_uart_tx_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} tx_state_t;

  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 115_200;
  localparam int unsigned FRAME_BITS   = 10;

  // Rounded-to-nearest clocks per bit.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input int unsigned baud);
    return (clk_freq + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/esp8266_uart_tx_fifo.sv
// Single-clock byte FIFO with extra-MSB pointers; flags and count are
// registered from next-state pointers so they line up with the data.
module esp8266_tx_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [AW:0]   count_nxt
);

  logic [7:0]  mem [2**AW];
  logic [AW:0] wptr, rptr, wptr_n, rptr_n;
  logic        wr, rd;

  assign wr        = push & ~full;
  assign rd        = pop & ~empty;
  assign wptr_n    = wptr + (AW+1)'(wr);
  assign rptr_n    = rptr + (AW+1)'(rd);
  assign count_nxt = wptr_n - rptr_n;
  assign dout      = mem[rptr[AW-1:0]];

  always_ff @(posedge Clk) begin
    if (wr) mem[wptr[AW-1:0]] <= din;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
      count <= '0;
    end else begin
      wptr  <= wptr_n;
      rptr  <= rptr_n;
      full  <= (wptr_n[AW] != rptr_n[AW]) && (wptr_n[AW-1:0] == rptr_n[AW-1:0]);
      empty <= (wptr_n == rptr_n);
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/esp8266_uart_tx.sv
// Strobe-driven byte capture into a FIFO, drained as back-to-back 8N1
// frames on a registered Tx line.
module esp8266_uart_tx
  import esp8266_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD,
  parameter int unsigned FIFO_AW  = 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Sig,
  input  logic [7:0]         Data_in,
  output logic               Tx,
  output logic               Busy,
  output logic               Fifo_full,
  output logic [FIFO_AW:0]   Fifo_count,
  output logic               Overflow
);

  localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD);
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             s1, s2, push, pop, fifo_empty, tick, tx_n;
  logic [7:0]       fifo_dout, shreg, sh_n;
  logic [FIFO_AW:0] count_nxt;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  tx_state_t        state, state_n;

  assign push = s1 & ~s2;
  assign tick = (cnt == CNT_W'(DIV - 1));

  esp8266_tx_fifo #(.AW(FIFO_AW)) u_fifo (
    .Clk       (Clk),
    .Rst_n     (Rst_n),
    .push      (push),
    .pop       (pop),
    .din       (Data_in),
    .dout      (fifo_dout),
    .full      (Fifo_full),
    .empty     (fifo_empty),
    .count     (Fifo_count),
    .count_nxt (count_nxt)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      s1       <= 1'b0;
      s2       <= 1'b0;
      state    <= ST_IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      Tx       <= 1'b1;
      Busy     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      s1      <= Sig;
      s2      <= s1;
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= sh_n;
      Tx      <= tx_n;
      // Registered from next-state values so Busy tracks the FIFO and FSM without lag.
      Busy    <= (state_n != ST_IDLE) || (count_nxt != '0);
      if (push && Fifo_full) Overflow <= 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    sh_n    = shreg;
    tx_n    = Tx;
    pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_n    = fifo_dout;
          tx_n    = 1'b0;
          cnt_n   = '0;
          state_n = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          cnt_n   = '0;
          bit_n   = '0;
          tx_n    = shreg[0];
          state_n = ST_DATA;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (tick) begin
          cnt_n = '0;
          if (bit_idx == 3'(FRAME_BITS - 3)) begin
            tx_n    = 1'b1;
            state_n = ST_STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
            sh_n  = {1'b0, shreg[7:1]};
            tx_n  = shreg[1];
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (tick) begin
          cnt_n = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_n    = fifo_dout;
            tx_n    = 1'b0;
            state_n = ST_START;
          end else begin
            tx_n    = 1'b1;
            state_n = ST_IDLE;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_esp8266_uart_tx.sv
// Directed/randomized bench for esp8266_uart_tx: a line monitor decodes
// frames from Tx and the main sequence compares them with expected bytes.
module tb_esp8266_uart_tx;

  localparam int unsigned CLK_FREQ = 1055;
  localparam int unsigned BAUD     = 100;
  localparam int unsigned FIFO_AW  = 4;
  localparam int unsigned DIV      = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int unsigned FRAME    = 10 * DIV;
  localparam int unsigned CAP      = 1 << FIFO_AW;

  logic             Clk = 1'b0;
  logic             Rst_n = 1'b0;
  logic             Sig = 1'b0;
  logic [7:0]       Data_in = '0;
  logic             Tx, Busy, Fifo_full, Overflow;
  logic [FIFO_AW:0] Fifo_count;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic [7:0]  b;
    bit          ok;
    int unsigned start;
  } frame_t;
  frame_t rx_q[$];

  esp8266_uart_tx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .FIFO_AW  (FIFO_AW)
  ) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .Sig        (Sig),
    .Data_in    (Data_in),
    .Tx         (Tx),
    .Busy       (Busy),
    .Fifo_full  (Fifo_full),
    .Fifo_count (Fifo_count),
    .Overflow   (Overflow)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  // Line monitor: a frame is 10 bits, each required to be constant for DIV cycles.
  initial begin
    logic        prev;
    logic        samp [FRAME];
    logic        aborted, ok, v;
    logic [7:0]  b;
    int unsigned st;
    frame_t      f;
    prev = 1'b1;
    forever begin
      @(negedge Clk);
      if (!Rst_n) begin
        prev = 1'b1;
      end else if (prev && !Tx) begin
        samp[0] = Tx;
        st      = cyc;
        aborted = 1'b0;
        for (int unsigned j = 1; j < FRAME; j++) begin
          @(negedge Clk);
          if (!Rst_n) begin
            aborted = 1'b1;
            break;
          end
          samp[j] = Tx;
        end
        if (aborted) begin
          prev = 1'b1;
        end else begin
          ok = (samp[0] === 1'b0) && (samp[9*DIV] === 1'b1);
          b  = '0;
          for (int unsigned i = 0; i < 10; i++) begin
            v = samp[i*DIV];
            for (int unsigned k = 1; k < DIV; k++)
              if (samp[i*DIV+k] !== v) ok = 1'b0;
            if (i >= 1 && i <= 8) b[i-1] = v;
          end
          f.b = b;
          f.ok = ok;
          f.start = st;
          rx_q.push_back(f);
          prev = samp[FRAME-1];
        end
      end else begin
        prev = Tx;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is at a negedge; Sig rises now and the first edge sampling it is returned.
  task automatic strobe(input logic [7:0] b, input int unsigned hi, input int unsigned lo,
                        output int unsigned e0);
    Data_in = b;
    Sig     = 1'b1;
    e0      = cyc + 1;
    repeat (hi) @(negedge Clk);
    Sig = 1'b0;
    repeat (lo) @(negedge Clk);
  endtask

  task automatic wait_frames(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(negedge Clk);
      k++;
    end
    check("frames_arrived", 32'(rx_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input int unsigned budget, output int unsigned fall);
    int unsigned k = 0;
    while (Busy !== 1'b0 && k < budget) begin
      @(negedge Clk);
      k++;
    end
    fall = cyc;
    check("busy_drops", 32'(k < budget), 32'd1);
  endtask

  initial begin
    int unsigned e0, e0a, fall, peak, n_acc, n;
    logic [7:0]  bytes[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  bv;

    repeat (3) @(negedge Clk);
    check("rst_tx", 32'(Tx), 32'd1);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_full", 32'(Fifo_full), 32'd0);
    check("rst_count", 32'(Fifo_count), 32'd0);
    check("rst_ovf", 32'(Overflow), 32'd0);
    Rst_n = 1'b1;
    repeat (3) @(negedge Clk);

    // Single byte 0x41: start edge two cycles after first Sig sample.
    strobe(8'h41, 2, 3, e0);
    wait_frames(1, FRAME + 20);
    wait_idle(FRAME + 20, fall);
    if (rx_q.size() >= 1) begin
      check("single_byte", 32'(rx_q[0].b), 32'h41);
      check("single_shape", 32'(rx_q[0].ok), 32'd1);
      check("single_start", rx_q[0].start, e0 + 2);
    end
    check("single_busy_span", fall - e0, FRAME + 2);
    check("single_idle_tx", 32'(Tx), 32'd1);
    rx_q.delete();

    // Sig held high: one push only.
    bv = 8'($urandom_range(0, 255));
    Data_in = bv;
    Sig = 1'b1;
    peak = 0;
    repeat (5 * FRAME) begin
      @(negedge Clk);
      if (32'(Fifo_count) > peak) peak = 32'(Fifo_count);
    end
    Sig = 1'b0;
    repeat (FRAME) @(negedge Clk);
    check("hold_frames", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() >= 1) check("hold_byte", 32'(rx_q[0].b), 32'(bv));
    check("hold_peak", peak, 32'd1);
    check("hold_count_end", 32'(Fifo_count), 32'd0);
    rx_q.delete();

    // Three bytes 10 cycles apart: contiguous frames.
    exp_q = '{8'h0D, 8'h0A, 8'h41};
    strobe(exp_q[0], 2, 8, e0);
    strobe(exp_q[1], 2, 8, e0a);
    strobe(exp_q[2], 2, 8, e0a);
    wait_idle(3 * FRAME + 20, fall);
    check("three_frames", 32'(rx_q.size()), 32'd3);
    check("three_busy_span", fall - e0, 3 * FRAME + 2);
    for (int unsigned i = 0; i < 3 && i < rx_q.size(); i++) begin
      check("three_byte", 32'(rx_q[i].b), 32'(exp_q[i]));
      check("three_shape", 32'(rx_q[i].ok), 32'd1);
      check("three_contig", rx_q[i].start, e0 + 2 + i * FRAME);
    end
    rx_q.delete();

    // Push coinciding with the next pop while two bytes are queued.
    exp_q.delete();
    for (int unsigned i = 0; i < 4; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    strobe(exp_q[0], 2, 3, e0a);
    strobe(exp_q[1], 2, 3, e0);
    strobe(exp_q[2], 2, 3, e0);
    while (cyc < e0a + FRAME) @(negedge Clk);
    check("coinc_pre_count", 32'(Fifo_count), 32'd2);
    Data_in = exp_q[3];
    Sig = 1'b1;
    repeat (2) @(negedge Clk);
    check("coinc_post_count", 32'(Fifo_count), 32'd2);
    Sig = 1'b0;
    wait_frames(4, 4 * FRAME + 20);
    for (int unsigned i = 0; i < 4 && i < rx_q.size(); i++)
      check("coinc_order", 32'(rx_q[i].b), 32'(exp_q[i]));
    check("coinc_no_ovf", 32'(Overflow), 32'd0);
    wait_idle(FRAME, fall);
    rx_q.delete();

    // Burst of 18 pushes 3 cycles apart: one in flight, CAP queued, rest dropped.
    n = 18;
    bytes.delete();
    for (int unsigned i = 0; i < n; i++) bytes.push_back(8'($urandom_range(0, 255)));
    for (int unsigned i = 0; i < n; i++) strobe(bytes[i], 2, 1, e0);
    n_acc = (n < CAP + 1) ? n : CAP + 1;
    check("burst_count", 32'(Fifo_count), n_acc - 1);
    check("burst_full", 32'(Fifo_full), 32'(n_acc - 1 == CAP));
    check("burst_ovf", 32'(Overflow), 32'(n > CAP + 1));
    wait_frames(n_acc, n_acc * FRAME + 20);
    for (int unsigned i = 0; i < n_acc && i < rx_q.size(); i++) begin
      check("burst_byte", 32'(rx_q[i].b), 32'(bytes[i]));
      check("burst_shape", 32'(rx_q[i].ok), 32'd1);
    end
    wait_idle(2 * FRAME, fall);
    check("burst_drained", 32'(Fifo_count), 32'd0);
    check("burst_ovf_sticky", 32'(Overflow), 32'd1);
    rx_q.delete();

    // Reset in the middle of data bit 3 of 0x55 with one more byte queued.
    strobe(8'h55, 2, 3, e0);
    strobe(8'($urandom_range(0, 255)), 2, 3, e0a);
    while (cyc < e0 + 2 + 4 * DIV + DIV / 2) @(negedge Clk);
    check("mid_bit3", 32'(Tx), 32'd0);
    check("mid_queued", 32'(Fifo_count), 32'd1);
    #2 Rst_n = 1'b0;
    #1;
    check("rst_async_tx", 32'(Tx), 32'd1);
    check("rst_async_count", 32'(Fifo_count), 32'd0);
    check("rst_async_busy", 32'(Busy), 32'd0);
    check("rst_async_ovf", 32'(Overflow), 32'd0);
    repeat (2) @(negedge Clk);
    Rst_n = 1'b1;
    repeat (3 * FRAME) @(negedge Clk);
    check("post_rst_silent", 32'(rx_q.size()), 32'd0);
    check("post_rst_tx", 32'(Tx), 32'd1);
    check("post_rst_busy", 32'(Busy), 32'd0);
    strobe(8'hA5, 2, 3, e0);
    wait_frames(1, FRAME + 20);
    if (rx_q.size() >= 1) begin
      check("post_rst_byte", 32'(rx_q[0].b), 32'hA5);
      check("post_rst_start", rx_q[0].start, e0 + 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
